ucmd_scheduler: RTL and testbench

Sequencer between the UART receiver and the command decoder of the dual watch. Accepts received bytes, keeps only recognised command codes in a small FIFO, and presents them to the decoder as single-cycle command strobes. Strobes are never issued in a cycle where a button command is active, and consecutive strobes are separated by a programmable gap. Each issued command is optionally echoed to the UART transmitter through a start/busy handshake.

---
 rtl/ucmd_scheduler.sv | 158 +++++++++++++++
 tb/tb_ucmd_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucmd_scheduler.sv
// Command sequencer between UART RX and the watch command decoder: filters
// received bytes into a FIFO, issues spaced command strobes, optionally echoes them to TX.
module ucmd_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter bit          ACK_EN     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          btn_busy,
  input  logic                          tx_busy,
  output logic [7:0]                    uart_command,
  output logic                          cmd_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_GAP} state_e;

  function automatic logic code_ok(input logic [7:0] b);
    case (b)
      8'h72, 8'h73, 8'h63, 8'h4C, 8'h52,
      8'h2B, 8'h2D, 8'h46, 8'h4D, 8'h43: code_ok = 1'b1;
      default:                           code_ok = 1'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      issue_q, issue_d;
  logic [7:0]      uart_command_q, uart_command_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            ovf_q, ovf_d;
  logic            push_req_c, push_c, pop_c, full_c;

  // FIFO bookkeeping, FSM next state and registered output values
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    gap_d          = gap_q;
    issue_d        = issue_q;
    uart_command_d = 8'h00;
    cmd_valid_d    = 1'b0;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    ovf_d          = ovf_q;

    full_c     = (count_q == CW'(FIFO_DEPTH));
    pop_c      = (state_q == S_IDLE) && (count_q != '0) && !btn_busy;
    push_req_c = rx_done && code_ok(rx_data);
    push_c     = push_req_c && (!full_c || pop_c);

    if (push_req_c && full_c && !pop_c) ovf_d = 1'b1;
    if (push_c) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);

    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          issue_d        = mem_q[rd_ptr_q];
          uart_command_d = mem_q[rd_ptr_q];
          cmd_valid_d    = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ACK_EN) begin
          state_d    = S_ACK;
          tx_start_d = !tx_busy;
          if (!tx_busy) tx_data_d = issue_q;
        end else if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_LOAD);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        // The strobe is launched from the previous cycle so tx_start stays a flop output
        if (tx_start_q) begin
          if (GAP_CYCLES != 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_LOAD);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tx_start_d = !tx_busy;
          if (!tx_busy) tx_data_d = issue_q;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      mem_q          <= '{default: 8'h00};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      gap_q          <= '0;
      issue_q        <= 8'h00;
      uart_command_q <= 8'h00;
      cmd_valid_q    <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      gap_q          <= gap_d;
      issue_q        <= issue_d;
      uart_command_q <= uart_command_d;
      cmd_valid_q    <= cmd_valid_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      ovf_q          <= ovf_d;
    end
  end

  assign uart_command = uart_command_q;
  assign cmd_valid    = cmd_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign fifo_count   = count_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_ucmd_scheduler.sv
// Bench for ucmd_scheduler: directed scenarios plus random traffic, each checked
// against a timeline/queue model of the command sequencing rules.
module tb_ucmd_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned VW    = 19 + CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_done = 1'b0, btn_busy = 1'b0, tx_busy = 1'b0;
  logic [7:0] uart_command, tx_data;
  logic cmd_valid, tx_start, ovf;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  ucmd_scheduler #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .btn_busy(btn_busy), .tx_busy(tx_busy), .uart_command(uart_command),
    .cmd_valid(cmd_valid), .tx_data(tx_data), .tx_start(tx_start),
    .fifo_count(fifo_count), .ovf(ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue contents plus the earliest cycle the next pop may happen
  logic [7:0] mq [$];
  int t = 0, ready_at = 0, echo_min = 0;
  bit wait_echo = 1'b0;
  logic [7:0] echo_b = 8'h00;
  logic [7:0] e_cmd = 8'h00, e_txd = 8'h00;
  logic e_cv = 1'b0, e_txs = 1'b0, e_ovf = 1'b0;
  logic [CW-1:0] e_cnt = '0;
  logic [7:0] codes [10] = '{8'h72, 8'h73, 8'h63, 8'h4C, 8'h52, 8'h2B, 8'h2D, 8'h46, 8'h4D, 8'h43};

  function automatic bit is_code(input logic [7:0] b);
    bit r = 1'b0;
    for (int i = 0; i < 10; i++) if (codes[i] == b) r = 1'b1;
    return r;
  endfunction

  function automatic logic [VW-1:0] obs();
    return {uart_command, cmd_valid, tx_data, tx_start, fifo_count, ovf};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {e_cmd, e_cv, e_txd, e_txs, e_cnt, e_ovf};
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge
  task automatic tick(input logic [7:0] d, input logic v, input logic b, input logic tb);
    bit pop;
    rx_data = d; rx_done = v; btn_busy = b; tx_busy = tb;
    e_cv = 1'b0; e_cmd = 8'h00; e_txs = 1'b0;
    if (wait_echo && t >= echo_min && !tb) begin
      e_txs = 1'b1; e_txd = echo_b; wait_echo = 1'b0;
      ready_at = t + 2 + int'(GAP);
    end
    pop = !wait_echo && (t >= ready_at) && (mq.size() != 0) && !b;
    if (pop) begin
      e_cv = 1'b1; e_cmd = mq.pop_front();
      wait_echo = 1'b1; echo_min = t + 1; echo_b = e_cmd;
    end
    if (v && is_code(d)) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(d);
      else e_ovf = 1'b1;
    end
    e_cnt = CW'(mq.size());
    @(posedge clk); #1;
    t++;
  endtask

  task automatic apply_reset();
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; btn_busy = 1'b0; tx_busy = 1'b0;
    mq.delete(); wait_echo = 1'b0;
    e_cmd = 8'h00; e_cv = 1'b0; e_txd = 8'h00; e_txs = 1'b0; e_cnt = '0; e_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ready_at = t;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== '0) begin n_err++; $display("FAIL reset_hold got=%h exp=0", obs()); end
    rx_data = 8'h72; rx_done = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== '0) begin n_err++; $display("FAIL reset_ignores_rx got=%h exp=0", obs()); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      tick(8'h72, k <= 1, 1'b0, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL single k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (k == 1) begin
        n_cmp++;
        if (!(cmd_valid === 1'b1 && uart_command === 8'h72)) begin
          n_err++; $display("FAIL single_issue_lat cv=%b cmd=%h exp 1/72", cmd_valid, uart_command);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (!(tx_start === 1'b1 && tx_data === 8'h72)) begin
          n_err++; $display("FAIL single_echo_lat txs=%b txd=%h exp 1/72", tx_start, tx_data);
        end
      end
      if (k == 5 || k == 6) begin
        n_cmp++;
        if (cmd_valid !== (k == 6)) begin
          n_err++; $display("FAIL single_next_issue k=%0d cv=%b exp %0d", k, cmd_valid, k == 6);
        end
      end
    end
  endtask

  task automatic test_filter();
    logic [7:0] bytes [3] = '{8'h41, 8'h2B, 8'h00};
    int peak = 0, nv = 0;
    logic [7:0] last = 8'h00;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      tick(k < 3 ? bytes[k] : 8'h00, k < 3, 1'b0, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL filter k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (cmd_valid) begin nv++; last = uart_command; end
    end
    n_cmp++;
    if (peak != 1) begin n_err++; $display("FAIL filter_peak got=%0d exp=1", peak); end
    n_cmp++;
    if (nv != 1 || last !== 8'h2B) begin n_err++; $display("FAIL filter_issued n=%0d cmd=%h exp 1/2b", nv, last); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL filter_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_overflow();
    logic [7:0] seq [6] = '{8'h72, 8'h73, 8'h63, 8'h4C, 8'h52, 8'h2B};
    logic [7:0] got [$];
    int when [$];
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      tick(k < 6 ? seq[k] : 8'h00, k < 6, 1'b0, k < 10);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL ovf_seq k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (cmd_valid) begin got.push_back(uart_command); when.push_back(k); end
      if (k == 9) begin
        n_cmp++;
        if (!(ovf === 1'b1 && fifo_count === CW'(4))) begin
          n_err++; $display("FAIL ovf_full ovf=%b cnt=%0d exp 1/4", ovf, fifo_count);
        end
      end
    end
    n_cmp++;
    if (got.size() != 5) begin
      n_err++; $display("FAIL ovf_issue_count got=%0d exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got[i] !== seq[i]) begin n_err++; $display("FAIL ovf_order i=%0d got=%h exp=%h", i, got[i], seq[i]); end
      end
      for (int i = 2; i < 5; i++) begin
        n_cmp++;
        if (when[i] - when[i-1] != 5) begin
          n_err++; $display("FAIL ovf_spacing i=%0d got=%0d exp=5", i, when[i] - when[i-1]);
        end
      end
    end
  endtask

  task automatic test_btn();
    int bad = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      tick(8'h46, k == 0, 1'b1, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL btn k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (cmd_valid !== 1'b0 || uart_command !== 8'h00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL btn_window got=%0d strobes exp=0", bad); end
    tick(8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (!(cmd_valid === 1'b1 && uart_command === 8'h46)) begin
      n_err++; $display("FAIL btn_release cv=%b cmd=%h exp 1/46", cmd_valid, uart_command);
    end
    for (int k = 0; k < 6; k++) begin
      tick(8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL btn_tail k=%0d got=%h exp=%h", k, obs(), expv()); end
    end
  endtask

  task automatic test_full_pop_wrap();
    logic [7:0] seq [5] = '{8'h4D, 8'h43, 8'h46, 8'h52, 8'h2D};
    logic [7:0] got [$];
    apply_reset();
    for (int k = 0; k < 4; k++) tick(seq[k], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL wrap_fill got=%0d exp=4", fifo_count); end
    tick(seq[4], 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (!(fifo_count === CW'(4) && ovf === 1'b0)) begin
      n_err++; $display("FAIL wrap_push_pop cnt=%0d ovf=%b exp 4/0", fifo_count, ovf);
    end
    if (cmd_valid) got.push_back(uart_command);
    for (int k = 0; k < 30; k++) begin
      tick(8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL wrap k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (cmd_valid) got.push_back(uart_command);
    end
    n_cmp++;
    if (got.size() != 5) begin
      n_err++; $display("FAIL wrap_count got=%0d exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got[i] !== seq[i]) begin n_err++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, got[i], seq[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    int ntx = 0;
    apply_reset();
    tick(8'h72, 1'b1, 1'b0, 1'b1);
    tick(8'h73, 1'b1, 1'b0, 1'b1);
    tick(8'h63, 1'b1, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (fifo_count !== CW'(2)) begin n_err++; $display("FAIL mid_ack_queued got=%0d exp=2", fifo_count); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin n_err++; $display("FAIL mid_ack_async got=%h exp=0", obs()); end
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      tick(8'h00, 1'b0, 1'b0, 1'b0);
      if (tx_start) ntx++;
    end
    n_cmp++;
    if (ntx != 0) begin n_err++; $display("FAIL mid_ack_lost_echo got=%0d exp=0", ntx); end
    tick(8'h2D, 1'b1, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (!(cmd_valid === 1'b1 && uart_command === 8'h2D)) begin
      n_err++; $display("FAIL mid_ack_fresh cv=%b cmd=%h exp 1/2d", cmd_valid, uart_command);
    end
  endtask

  task automatic test_random();
    logic tb = 1'b0;
    logic [7:0] d;
    apply_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) tb = ~tb;
      d = ($urandom_range(0, 9) < 7) ? codes[$urandom_range(0, 9)] : 8'($urandom);
      tick(d, $urandom_range(0, 9) < 4, $urandom_range(0, 6) == 0, tb);
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL random k=%0d got=%h exp=%h", k, obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_btn();
    test_full_pop_wrap();
    test_reset_mid_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
